// File: rtl/fifo_rr_arbiter_pkg.sv
// rtl/fifo_rr_arbiter_pkg.sv - shared types, constants and helpers for the FIFO write-port arbiter
// Contents: arb_state_t (IDLE/GRANT), STAT_W (statistics counter width),
//           next_idx(ptr, n) modulo-n increment that is safe for non-power-of-2 n.
package fifo_arb_pkg;

  typedef enum logic {IDLE, GRANT} arb_state_t;

  localparam int STAT_W = 16;

  function automatic int next_idx(input int ptr, input int n);
    return (ptr + 1 >= n) ? 0 : ptr + 1;
  endfunction

endpackage

// File: rtl/fifo_rr_arbiter_if.sv
// rtl/fifo_rr_arbiter_if.sv - producer handshake + FIFO write-port bundle for the arbiter
// Signals: req_valid/req_data/req_last/req_ready  producer side, one lane per requester
//          fifo_din/fifo_we/fifo_flagf             FIFO write pins
//          grant_valid/grant_id                    current ownership
// Modports: slave = arbiter, master = producers + FIFO environment.
interface fifo_rr_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 8
);
  localparam int IDX_W = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic [NUM_REQ-1:0]        req_last;
  logic [NUM_REQ-1:0]        req_ready;
  logic [DATA_W-1:0]         fifo_din;
  logic                      fifo_we;
  logic                      fifo_flagf;
  logic                      grant_valid;
  logic [IDX_W-1:0]          grant_id;

  modport slave (
    input  req_valid, req_data, req_last, fifo_flagf,
    output req_ready, fifo_din, fifo_we, grant_valid, grant_id
  );

  modport master (
    output req_valid, req_data, req_last, fifo_flagf,
    input  req_ready, fifo_din, fifo_we, grant_valid, grant_id
  );

endinterface

// File: rtl/fifo_rr_arbiter_rr_pick.sv
// rtl/fifo_rr_arbiter_rr_pick.sv - combinational rotating priority encoder
// Ports: req    in   requester valid vector
//        start  in   index with highest priority
//        found  out  at least one req bit set
//        idx    out  first set index scanning start, start+1, ... modulo NUM_REQ
module rr_pick #(
  parameter  int NUM_REQ = 4,
  localparam int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   start,
  output logic               found,
  output logic [IDX_W-1:0]   idx
);

  int j;

  // Scan from farthest to nearest so the nearest set bit is the last writer.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    j     = 0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      j = int'(start) + k;
      if (j >= NUM_REQ) j = j - NUM_REQ;
      if (req[j]) begin
        found = 1'b1;
        idx   = IDX_W'(j);
      end
    end
  end

endmodule

// File: rtl/fifo_rr_arbiter.sv
// rtl/fifo_rr_arbiter.sv - round-robin arbiter sharing one FIFO write port among NUM_REQ producers
// Ports: clk           in   rising-edge clock
//        rst           in   asynchronous active-low reset
//        bus           if   fifo_rr_arbiter_if.slave (producer handshakes, FIFO din/we/flagf, grant)
//        beat_total    out  per-requester saturating accepted-beat counters (FIFO_ARB_STATS_EN only)
//        stall_cycles  out  saturating count of owner-blocked-by-full cycles (FIFO_ARB_STATS_EN only)
// Optional feature macro: FIFO_ARB_STATS_EN
module fifo_rr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int NUM_REQ   = 4,
  parameter int DATA_W    = 8,
  parameter int MAX_BURST = 4
) (
  input  logic                      clk,
  input  logic                      rst,
`ifdef FIFO_ARB_STATS_EN
  output logic [NUM_REQ*STAT_W-1:0] beat_total,
  output logic [STAT_W-1:0]         stall_cycles,
`endif
  fifo_rr_arbiter_if.slave          bus
);

  localparam int IDX_W = $clog2(NUM_REQ);

  arb_state_t       state, state_nxt;
  logic [IDX_W-1:0] rr_ptr, rr_ptr_nxt;
  logic [IDX_W-1:0] grant_id, grant_id_nxt;
  logic [3:0]       beat_cnt, beat_cnt_nxt;
  logic             pick_found;
  logic [IDX_W-1:0] pick_idx;
  logic             owner_valid, owner_last, accept, release_grant;
  logic [DATA_W-1:0] owner_data;

  rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
    .req   (bus.req_valid),
    .start (rr_ptr),
    .found (pick_found),
    .idx   (pick_idx)
  );

  assign owner_valid = bus.req_valid[grant_id];
  assign owner_last  = bus.req_last[grant_id];
  assign owner_data  = bus.req_data[int'(grant_id)*DATA_W +: DATA_W];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      rr_ptr   <= '0;
      grant_id <= '0;
      beat_cnt <= '0;
    end else begin
      state    <= state_nxt;
      rr_ptr   <= rr_ptr_nxt;
      grant_id <= grant_id_nxt;
      beat_cnt <= beat_cnt_nxt;
    end
  end

  // Outputs depend on state, so the async reset clears them without a clock.
  always_comb begin
    state_nxt     = state;
    rr_ptr_nxt    = rr_ptr;
    grant_id_nxt  = grant_id;
    beat_cnt_nxt  = beat_cnt;
    accept        = 1'b0;
    release_grant = 1'b0;
    bus.req_ready = '0;
    bus.fifo_we   = 1'b0;
    bus.fifo_din  = '0;
    case (state)
      IDLE: begin
        if (pick_found) begin
          state_nxt    = GRANT;
          grant_id_nxt = pick_idx;
          beat_cnt_nxt = '0;
        end
      end
      GRANT: begin
        bus.req_ready[grant_id] = ~bus.fifo_flagf;
        accept      = owner_valid & ~bus.fifo_flagf;
        bus.fifo_we = accept;
        if (accept) begin
          bus.fifo_din = owner_data;
          beat_cnt_nxt = beat_cnt + 4'd1;
        end
        // A full FIFO freezes everything; only a non-full idle owner releases.
        release_grant = (accept & (owner_last | (beat_cnt + 4'd1 == 4'(MAX_BURST))))
                      | (~owner_valid & ~bus.fifo_flagf);
        if (release_grant) begin
          state_nxt    = IDLE;
          rr_ptr_nxt   = IDX_W'(next_idx(int'(grant_id), NUM_REQ));
          beat_cnt_nxt = '0;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign bus.grant_valid = (state == GRANT);
  assign bus.grant_id    = grant_id;

`ifdef FIFO_ARB_STATS_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      beat_total   <= '0;
      stall_cycles <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (accept && grant_id == IDX_W'(i) && beat_total[i*STAT_W +: STAT_W] != '1)
          beat_total[i*STAT_W +: STAT_W] <= beat_total[i*STAT_W +: STAT_W] + STAT_W'(1);
      end
      if (state == GRANT && owner_valid && bus.fifo_flagf && stall_cycles != '1)
        stall_cycles <= stall_cycles + STAT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_fifo_rr_arbiter.sv
// tb/tb_fifo_rr_arbiter.sv - directed-vector bench for fifo_rr_arbiter
module tb_fifo_rr_arbiter;

  typedef struct {
    logic        r;
    logic [3:0]  v;
    logic [31:0] d;
    logic [3:0]  l;
    logic        f;
    logic [3:0]  rdy;
    logic        we;
    logic [7:0]  din;
    logic        gv;
    logic [1:0]  gid;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_vec  = 0;
  int   n_miss = 0;

  always #5 clk = ~clk;

  fifo_rr_arbiter_if #(.NUM_REQ(4), .DATA_W(8)) bus ();

`ifdef FIFO_ARB_STATS_EN
  logic [63:0] beat_total;
  logic [15:0] stall_cycles;
`endif

  fifo_rr_arbiter #(.NUM_REQ(4), .DATA_W(8), .MAX_BURST(4)) dut (
    .clk          (clk),
    .rst          (rst),
`ifdef FIFO_ARB_STATS_EN
    .beat_total   (beat_total),
    .stall_cycles (stall_cycles),
`endif
    .bus          (bus)
  );

  function automatic vec_t mk(logic r, logic [3:0] v, logic [31:0] d, logic [3:0] l, logic f,
                              logic [3:0] rdy, logic we, logic [7:0] din, logic gv, logic [1:0] gid);
    vec_t t;
    t.r = r; t.v = v; t.d = d; t.l = l; t.f = f;
    t.rdy = rdy; t.we = we; t.din = din; t.gv = gv; t.gid = gid;
    return t;
  endfunction

  task automatic drive(input logic r, input logic [3:0] v, input logic [31:0] d,
                       input logic [3:0] l, input logic f);
    @(posedge clk);
    #1;
    rst            = r;
    bus.req_valid  = v;
    bus.req_data   = d;
    bus.req_last   = l;
    bus.fifo_flagf = f;
    @(negedge clk);
  endtask

  task automatic check(input string name, input logic [3:0] rdy, input logic we, input logic [7:0] din,
                       input logic gv, input logic [1:0] gid, input logic chk_gid);
    n_vec++;
    if (bus.req_ready !== rdy || bus.fifo_we !== we || bus.fifo_din !== din ||
        bus.grant_valid !== gv || (chk_gid && bus.grant_id !== gid)) begin
      n_miss++;
      $display("FAIL %s: got rdy=%b we=%b din=%h gv=%b gid=%0d, want rdy=%b we=%b din=%h gv=%b gid=%0d",
               name, bus.req_ready, bus.fifo_we, bus.fifo_din, bus.grant_valid, bus.grant_id,
               rdy, we, din, gv, gid);
    end
  endtask

  vec_t        vecs [28];
  logic [3:0]  cnt  [4];
  logic [31:0] d;
  logic [1:0]  egid;
  logic [3:0]  ebeat;

  initial begin
    bus.req_valid  = '0;
    bus.req_data   = '0;
    bus.req_last   = '0;
    bus.fifo_flagf = 1'b0;

    //           r  v     d             l     f     rdy   we din    gv gid
    vecs[0]  = mk(0, 4'hF, 32'h0,        4'h0, 1'b0, 4'h0, 0, 8'h00, 0, 0);
    vecs[1]  = mk(0, 4'hF, 32'h0,        4'h0, 1'b0, 4'h0, 0, 8'h00, 0, 0);
    vecs[2]  = mk(1, 4'hF, 32'h0,        4'h0, 1'b0, 4'h0, 0, 8'h00, 0, 0);
    vecs[3]  = mk(1, 4'h0, 32'h0,        4'h0, 1'b0, 4'h1, 0, 8'h00, 1, 0);
    vecs[4]  = mk(1, 4'h4, 32'h00A00000, 4'h0, 1'b0, 4'h0, 0, 8'h00, 0, 0);
    vecs[5]  = mk(1, 4'h4, 32'h00A00000, 4'h0, 1'b0, 4'h4, 1, 8'hA0, 1, 2);
    vecs[6]  = mk(1, 4'h4, 32'h00A10000, 4'h4, 1'b0, 4'h4, 1, 8'hA1, 1, 2);
    vecs[7]  = mk(1, 4'h0, 32'h0,        4'h0, 1'b0, 4'h0, 0, 8'h00, 0, 2);
    vecs[8]  = mk(1, 4'hF, 32'h0,        4'h0, 1'b0, 4'h0, 0, 8'h00, 0, 2);
    vecs[9]  = mk(1, 4'h0, 32'h0,        4'h0, 1'b0, 4'h8, 0, 8'h00, 1, 3);
    vecs[10] = mk(1, 4'h2, 32'h00001000, 4'h0, 1'b0, 4'h0, 0, 8'h00, 0, 3);
    vecs[11] = mk(1, 4'h2, 32'h00001000, 4'h0, 1'b0, 4'h2, 1, 8'h10, 1, 1);
    vecs[12] = mk(1, 4'h2, 32'h00001100, 4'h0, 1'b0, 4'h2, 1, 8'h11, 1, 1);
    for (int i = 13; i < 18; i++)
      vecs[i] = mk(1, 4'h2, 32'h00001200, 4'h0, 1'b1, 4'h0, 0, 8'h00, 1, 1);
    vecs[18] = mk(1, 4'h2, 32'h00001200, 4'h0, 1'b0, 4'h2, 1, 8'h12, 1, 1);
    vecs[19] = mk(1, 4'h2, 32'h00001300, 4'h0, 1'b0, 4'h2, 1, 8'h13, 1, 1);
    vecs[20] = mk(1, 4'h0, 32'h0,        4'h0, 1'b0, 4'h0, 0, 8'h00, 0, 1);
    vecs[21] = mk(1, 4'h1, 32'h00000055, 4'h0, 1'b0, 4'h0, 0, 8'h00, 0, 1);
    vecs[22] = mk(1, 4'h9, 32'h77000055, 4'h0, 1'b0, 4'h1, 1, 8'h55, 1, 0);
    vecs[23] = mk(1, 4'h8, 32'h77000000, 4'h0, 1'b0, 4'h1, 0, 8'h00, 1, 0);
    vecs[24] = mk(1, 4'h8, 32'h77000000, 4'h0, 1'b0, 4'h0, 0, 8'h00, 0, 0);
    vecs[25] = mk(1, 4'h8, 32'h77000000, 4'h0, 1'b0, 4'h8, 1, 8'h77, 1, 3);
    vecs[26] = mk(1, 4'h0, 32'h0,        4'h0, 1'b0, 4'h8, 0, 8'h00, 1, 3);
    vecs[27] = mk(1, 4'h0, 32'h0,        4'h0, 1'b0, 4'h0, 0, 8'h00, 0, 3);

    for (int i = 0; i < 28; i++) begin
      drive(vecs[i].r, vecs[i].v, vecs[i].d, vecs[i].l, vecs[i].f);
      check($sformatf("vec%0d", i), vecs[i].rdy, vecs[i].we, vecs[i].din, vecs[i].gv, vecs[i].gid, 1'b1);
    end

`ifdef FIFO_ARB_STATS_EN
    n_vec++;
    if (beat_total !== 64'h0001_0002_0004_0001 || stall_cycles !== 16'd5) begin
      n_miss++;
      $display("FAIL stats: got beat_total=%h stall=%0d, want beat_total=0001000200040001 stall=5",
               beat_total, stall_cycles);
    end
`endif

    // Round robin with every requester valid: 5-cycle rhythm of IDLE + 4 beats.
    for (int i = 0; i < 4; i++) cnt[i] = 4'h0;
    for (int c = 0; c < 25; c++) begin
      for (int i = 0; i < 4; i++) d[i*8 +: 8] = {4'(i), cnt[i]};
      drive(1, 4'hF, d, 4'h0, 1'b0);
      if (c % 5 == 0) begin
        check($sformatf("rr_idle%0d", c), 4'h0, 0, 8'h00, 0, 2'd0, 1'b0);
      end else begin
        egid  = 2'((c / 5) % 4);
        ebeat = 4'((c / 20) * 4 + (c % 5) - 1);
        check($sformatf("rr_beat%0d", c), 4'(1 << egid), 1, {2'b00, egid, ebeat}, 1, egid, 1'b1);
      end
      for (int i = 0; i < 4; i++)
        if (bus.req_ready[i] && bus.req_valid[i]) cnt[i] = cnt[i] + 4'h1;
    end

    // Reset in the middle of req1's burst, then arbitration restarts from 0.
    for (int c = 25; c < 28; c++) begin
      for (int i = 0; i < 4; i++) d[i*8 +: 8] = {4'(i), cnt[i]};
      drive(1, 4'hF, d, 4'h0, 1'b0);
      if (c == 25) check("mid_idle", 4'h0, 0, 8'h00, 0, 2'd0, 1'b0);
      else check($sformatf("mid_beat%0d", c), 4'h2, 1, 8'h14 + 8'(c - 26), 1, 2'd1, 1'b1);
      for (int i = 0; i < 4; i++)
        if (bus.req_ready[i] && bus.req_valid[i]) cnt[i] = cnt[i] + 4'h1;
    end
    for (int i = 0; i < 4; i++) d[i*8 +: 8] = {4'(i), cnt[i]};
    drive(0, 4'hF, d, 4'h0, 1'b0);
    check("rst_async", 4'h0, 0, 8'h00, 0, 2'd0, 1'b1);
    drive(0, 4'hF, d, 4'h0, 1'b0);
    check("rst_hold", 4'h0, 0, 8'h00, 0, 2'd0, 1'b1);
`ifdef FIFO_ARB_STATS_EN
    n_vec++;
    if (beat_total !== 64'h0 || stall_cycles !== 16'h0) begin
      n_miss++;
      $display("FAIL stats_rst: got beat_total=%h stall=%0d, want 0 and 0", beat_total, stall_cycles);
    end
`endif
    drive(1, 4'hF, d, 4'h0, 1'b0);
    check("post_rst_idle", 4'h0, 0, 8'h00, 0, 2'd0, 1'b1);
    drive(1, 4'hF, d, 4'h0, 1'b0);
    check("post_rst_grant", 4'h1, 1, {4'h0, cnt[0]}, 1, 2'd0, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
